// File: rtl/dbus_ctrl_if.sv
// Core data-bus bundle: request side driven by the core, completion by dbus_ctrl.
interface dbus_ctrl_if;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  logic [31:0] DDT_in;
  logic [31:0] DDT_out;
  logic        ACKD_n;

  modport master (output MREQ, WRITE, SIZE, DAD, DDT_in, input DDT_out, ACKD_n);
  modport slave  (input MREQ, WRITE, SIZE, DAD, DDT_in, output DDT_out, ACKD_n);
endinterface

// File: rtl/dbus_ctrl.sv
// Data-bus controller: SRAM window, console byte FIFO and exit port behind a
// single-outstanding request/ack bus with a fixed completion latency.
module dbus_ctrl #(
  parameter int          LATENCY     = 1,
  parameter logic [31:0] DMEM_BASE   = 32'h0800_0000,
  parameter int          DMEM_AW     = 10,
  parameter logic [31:0] STDOUT_ADDR = 32'hf000_0000,
  parameter logic [31:0] EXIT_ADDR   = 32'hff00_0000,
  parameter int          TXQ_DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  dbus_ctrl_if.slave         bus,
  output logic               sram_en,
  output logic               sram_we,
  output logic [3:0]         sram_be,
  output logic [DMEM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               exit_o,
  output logic [31:0]        exit_code,
  output logic               err_o
);
  localparam int QW = $clog2(TXQ_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t r_state, w_next;

  logic [3:0]  r_cnt;
  logic [1:0]  r_size, r_lane;
  logic        r_rd_pend;
  logic [31:0] r_ldata, r_dout;
  logic [7:0]  r_q [TXQ_DEPTH];
  logic [QW:0] r_wp, r_rp;

  logic        w_word, w_half, w_misal, w_in_mem, w_is_out, w_is_exit, w_err;
  logic        w_accept, w_mem_ok, w_push, w_pop, w_full, w_empty;
  logic [31:0] w_off, w_rd_data, w_cur, w_sh;

  assign w_word    = (bus.SIZE == 2'b00);
  assign w_half    = (bus.SIZE == 2'b01);
  assign w_misal   = (w_word && bus.DAD[1:0] != 2'b00) || (w_half && bus.DAD[0]);
  assign w_off     = bus.DAD - DMEM_BASE;
  assign w_in_mem  = (w_off >> (DMEM_AW + 2)) == 32'd0;
  assign w_is_out  = (bus.DAD == STDOUT_ADDR);
  assign w_is_exit = (bus.DAD == EXIT_ADDR);
  assign w_err     = w_misal || !(w_in_mem || w_is_out || w_is_exit);
  assign w_mem_ok  = w_in_mem && !w_misal;

  // A console store with no free slot waits in IDLE; a same-cycle pop does not help.
  assign w_push   = r_state == IDLE && bus.MREQ && bus.WRITE && w_is_out && !w_misal;
  assign w_accept = r_state == IDLE && bus.MREQ && !(w_push && w_full);

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = 32'd0;
    if (!rst && w_accept && w_mem_ok) begin
      sram_en   = 1'b1;
      sram_we   = bus.WRITE;
      sram_addr = bus.DAD[DMEM_AW+1:2];
      if (w_word) begin
        sram_be    = 4'b1111;
        sram_wdata = bus.DDT_in;
      end else if (w_half) begin
        sram_be    = bus.DAD[1] ? 4'b1100 : 4'b0011;
        sram_wdata = {2{bus.DDT_in[15:0]}};
      end else begin
        sram_be    = 4'b0001 << bus.DAD[1:0];
        sram_wdata = {4{bus.DDT_in[7:0]}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (LATENCY == 1) ? ACK : WAIT;
      WAIT:    if (r_cnt == 4'd1) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                r_cnt <= 4'd0;
    else if (w_accept)                      r_cnt <= 4'(LATENCY - 1);
    else if (r_state == WAIT && r_cnt != 4'd1) r_cnt <= r_cnt - 4'd1;
  end

  assign w_sh = sram_rdata >> {r_lane, 3'b000};
  always_comb begin
    case (r_size)
      2'b00:   w_rd_data = sram_rdata;
      2'b01:   w_rd_data = {16'd0, r_lane[1] ? sram_rdata[31:16] : sram_rdata[15:0]};
      default: w_rd_data = {24'd0, w_sh[7:0]};
    endcase
  end

  // SRAM data is only valid the cycle after the access; later acks use the latched copy.
  assign w_cur       = r_rd_pend ? w_rd_data : r_ldata;
  assign bus.DDT_out = (r_state == ACK) ? w_cur : r_dout;
  assign bus.ACKD_n  = (r_state != ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_size    <= 2'b00;
      r_lane    <= 2'b00;
      r_ldata   <= 32'd0;
      r_dout    <= 32'd0;
      err_o     <= 1'b0;
      exit_o    <= 1'b0;
      exit_code <= 32'd0;
    end else begin
      r_rd_pend <= w_accept && w_mem_ok && !bus.WRITE;
      if (w_accept) begin
        r_size  <= bus.SIZE;
        r_lane  <= bus.DAD[1:0];
        r_ldata <= 32'd0;
        if (w_err) err_o <= 1'b1;
        if (bus.WRITE && w_is_exit && !w_misal && !exit_o) begin
          exit_o    <= 1'b1;
          exit_code <= bus.DDT_in;
        end
      end else if (r_rd_pend) begin
        r_ldata <= w_rd_data;
      end
      if (r_state == ACK) r_dout <= w_cur;
    end
  end

  assign w_empty  = (r_wp == r_rp);
  assign w_full   = ((r_wp - r_rp) == (QW+1)'(TXQ_DEPTH));
  assign w_pop    = !w_empty && tx_ready;
  assign tx_valid = !w_empty;
  assign tx_data  = w_empty ? 8'd0 : r_q[r_rp[QW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push && w_accept) r_wp <= r_wp + 1'b1;
      if (w_pop)              r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && w_accept && !rst) r_q[r_wp[QW-1:0]] <= bus.DDT_in[7:0];
  end
endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl: three instances at LATENCY 1, 3 and 4, each with its own SRAM model.
module tb_dbus_ctrl;
  localparam logic [31:0] OUTA = 32'hf000_0000;
  localparam logic [31:0] EXA  = 32'hff00_0000;

  logic        clk = 1'b0;
  logic        rst [3];
  logic        mreq [3], wr [3], ack_n [3];
  logic [1:0]  sz [3];
  logic [31:0] dad [3], din [3], ddt_out [3];
  logic        sram_en [3], sram_we [3], tx_valid [3], tx_ready [3], exit_o [3], err_o [3];
  logic [3:0]  sram_be [3];
  logic [9:0]  sram_addr [3];
  logic [31:0] sram_wdata [3], sram_rdata [3], exit_code [3];
  logic [7:0]  tx_data [3];
  logic [31:0] mem [3][1024];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 3; g++) begin : gi
    dbus_ctrl_if bus ();
    assign bus.MREQ   = mreq[g];
    assign bus.WRITE  = wr[g];
    assign bus.SIZE   = sz[g];
    assign bus.DAD    = dad[g];
    assign bus.DDT_in = din[g];
    assign ddt_out[g] = bus.DDT_out;
    assign ack_n[g]   = bus.ACKD_n;
    dbus_ctrl #(.LATENCY((g == 0) ? 1 : (g == 1) ? 3 : 4)) u_dut (
      .clk(clk), .rst(rst[g]), .bus(bus),
      .sram_en(sram_en[g]), .sram_we(sram_we[g]), .sram_be(sram_be[g]),
      .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata[g]),
      .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_data(tx_data[g]),
      .exit_o(exit_o[g]), .exit_code(exit_code[g]), .err_o(err_o[g]));
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sram_en[k]) begin
        sram_rdata[k] <= mem[k][sram_addr[k]];
        if (sram_we[k])
          for (int b = 0; b < 4; b++)
            if (sram_be[k][b]) mem[k][sram_addr[k]][8*b +: 8] <= sram_wdata[k][8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advances one cycle, presents a request, then holds MREQ until the ack.
  // n = cycles from the presenting cycle to the ack, -1 on timeout.
  task automatic xact(input int k, input logic w, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] d, output int n, output logic [31:0] dout,
                      output logic en, output logic [3:0] be, output logic [31:0] wd);
    @(posedge clk); #1;
    mreq[k] = 1'b1; wr[k] = w; sz[k] = s; dad[k] = a; din[k] = d;
    #1;
    en = sram_en[k]; be = sram_be[k]; wd = sram_wdata[k];
    n = -1; dout = 32'hx;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (!ack_n[k]) begin
        n = c + 1; dout = ddt_out[k];
        break;
      end
    end
    mreq[k] = 1'b0;
  endtask

  function automatic logic [31:0] be2mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic [31:0] a, d;
    logic        en;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ld;
    logic [31:0] dout;
    logic        err;
  } vec_t;

  vec_t tv [16];

  initial begin
    int n, got;
    logic [31:0] dout, wd;
    logic en;
    logic [3:0] be;

    tv[0]  = '{1'b1, 2'd0, 32'h0800_0000, 32'h1122_3344, 1'b1, 4'b1111, 32'h1122_3344, 1'b0, 32'h0, 1'b0};
    tv[1]  = '{1'b1, 2'd2, 32'h0800_0003, 32'h0000_005A, 1'b1, 4'b1000, 32'h5A00_0000, 1'b0, 32'h0, 1'b0};
    tv[2]  = '{1'b0, 2'd1, 32'h0800_0002, 32'h0,         1'b1, 4'b1100, 32'h0, 1'b1, 32'h0000_5A22, 1'b0};
    tv[3]  = '{1'b0, 2'd2, 32'h0800_0001, 32'h0,         1'b1, 4'b0010, 32'h0, 1'b1, 32'h0000_0033, 1'b0};
    tv[4]  = '{1'b0, 2'd1, 32'h0800_0000, 32'h0,         1'b1, 4'b0011, 32'h0, 1'b1, 32'h0000_3344, 1'b0};
    tv[5]  = '{1'b0, 2'd0, 32'h0800_0000, 32'h0,         1'b1, 4'b1111, 32'h0, 1'b1, 32'h5A22_3344, 1'b0};
    tv[6]  = '{1'b1, 2'd0, 32'h0800_0004, 32'h0,         1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0};
    tv[7]  = '{1'b1, 2'd1, 32'h0800_0006, 32'h1234_BEEF, 1'b1, 4'b1100, 32'hBEEF_0000, 1'b0, 32'h0, 1'b0};
    tv[8]  = '{1'b0, 2'd0, 32'h0800_0004, 32'h0,         1'b1, 4'b1111, 32'h0, 1'b1, 32'hBEEF_0000, 1'b0};
    tv[9]  = '{1'b0, 2'd3, 32'h0800_0007, 32'h0,         1'b1, 4'b1000, 32'h0, 1'b1, 32'h0000_00BE, 1'b0};
    tv[10] = '{1'b1, 2'd0, 32'h0800_0FFC, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0};
    tv[11] = '{1'b0, 2'd0, 32'h0800_0FFC, 32'h0,         1'b1, 4'b1111, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
    tv[12] = '{1'b0, 2'd0, OUTA,          32'h0,         1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b0};
    tv[13] = '{1'b0, 2'd0, 32'h0800_1000, 32'h0,         1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b1};
    tv[14] = '{1'b0, 2'd1, 32'h0800_0001, 32'h0,         1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b1};
    tv[15] = '{1'b0, 2'd0, 32'h07FF_FFFC, 32'h0,         1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b1};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; mreq[k] = 1'b0; wr[k] = 1'b0; sz[k] = 2'd0; dad[k] = 32'd0; din[k] = 32'd0;
      tx_ready[k] = 1'b0;
    end
    tx_ready[0] = 1'b1;

    // Reset state and SRAM outputs held low during reset.
    repeat (2) begin @(posedge clk); #1; end
    mreq[1] = 1'b1; wr[1] = 1'b1; dad[1] = 32'h0800_0000; din[1] = 32'h1;
    #1;
    chk("rst_sram_en", 32'(sram_en[1]), 32'd0);
    chk("rst_sram_we", 32'(sram_we[1]), 32'd0);
    chk("rst_sram_be", 32'(sram_be[1]), 32'd0);
    mreq[1] = 1'b0;
    chk("rst_ack_n", 32'(ack_n[1]), 32'd1);
    chk("rst_dout", ddt_out[1], 32'd0);
    chk("rst_tx_valid", 32'(tx_valid[1]), 32'd0);
    chk("rst_tx_data", 32'(tx_data[1]), 32'd0);
    chk("rst_exit_o", 32'(exit_o[1]), 32'd0);
    chk("rst_exit_code", exit_code[1], 32'd0);
    chk("rst_err_o", 32'(err_o[1]), 32'd0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // LATENCY=1 word store then load.
    xact(0, 1'b1, 2'd0, 32'h0800_0004, 32'hDEAD_BEEF, n, dout, en, be, wd);
    chk("l1_st_en", 32'(en), 32'd1);
    chk("l1_st_be", 32'(be), 32'hf);
    chk("l1_st_lat", n, 1);
    xact(0, 1'b0, 2'd0, 32'h0800_0004, 32'h0, n, dout, en, be, wd);
    chk("l1_ld_lat", n, 1);
    chk("l1_ld_dout", dout, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("l1_ack_once", 32'(ack_n[0]), 32'd1);
    chk("l1_dout_hold", ddt_out[0], 32'hDEAD_BEEF);
    xact(0, 1'b0, 2'd0, 32'h0800_0002, 32'h0, n, dout, en, be, wd);
    chk("mis_en", 32'(en), 32'd0);
    chk("mis_lat", n, 1);
    chk("mis_dout", dout, 32'd0);
    chk("mis_err", 32'(err_o[0]), 32'd1);

    // LATENCY=3 vector table.
    for (int i = 0; i < 16; i++) begin
      xact(1, tv[i].w, tv[i].s, tv[i].a, tv[i].d, n, dout, en, be, wd);
      chk($sformatf("v%0d_en", i), 32'(en), 32'(tv[i].en));
      if (tv[i].en) chk($sformatf("v%0d_be", i), 32'(be), 32'(tv[i].be));
      if (tv[i].en && tv[i].w) chk($sformatf("v%0d_wd", i), wd & be2mask(tv[i].be), tv[i].wd);
      chk($sformatf("v%0d_lat", i), n, 3);
      if (tv[i].ld) chk($sformatf("v%0d_dout", i), dout, tv[i].dout);
      chk($sformatf("v%0d_err", i), 32'(err_o[1]), 32'(tv[i].err));
    end

    // Console FIFO fill, stall on full, one pop releases the stalled store.
    for (int i = 0; i < 8; i++) begin
      xact(1, 1'b1, 2'd2, OUTA, 32'h30 + i, n, dout, en, be, wd);
      chk($sformatf("tx%0d_lat", i), n, 3);
    end
    @(posedge clk); #1;
    mreq[1] = 1'b1; wr[1] = 1'b1; sz[1] = 2'd2; dad[1] = OUTA; din[1] = 32'h38;
    got = 0;
    repeat (10) begin @(posedge clk); #1; if (!ack_n[1]) got++; end
    chk("tx_stall_noack", got, 0);
    chk("tx_full_valid", 32'(tx_valid[1]), 32'd1);
    chk("tx_head", 32'(tx_data[1]), 32'h30);
    tx_ready[1] = 1'b1;
    @(posedge clk); #1;
    tx_ready[1] = 1'b0;
    n = -1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!ack_n[1]) begin n = c + 1; break; end
    end
    mreq[1] = 1'b0;
    chk("tx_ninth_lat", n, 3);
    tx_ready[1] = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk($sformatf("tx_drain%0d_v", i), 32'(tx_valid[1]), 32'd1);
      chk($sformatf("tx_drain%0d_d", i), 32'(tx_data[1]), 32'h30 + i);
      @(posedge clk); #1;
    end
    chk("tx_empty", 32'(tx_valid[1]), 32'd0);
    tx_ready[1] = 1'b0;

    // Exit port is write-once.
    xact(1, 1'b1, 2'd0, EXA, 32'h2A, n, dout, en, be, wd);
    chk("exit_lat", n, 3);
    chk("exit_o", 32'(exit_o[1]), 32'd1);
    chk("exit_code", exit_code[1], 32'h2A);
    xact(1, 1'b1, 2'd0, EXA, 32'h7, n, dout, en, be, wd);
    chk("exit2_lat", n, 3);
    chk("exit2_code", exit_code[1], 32'h2A);

    // LATENCY=4: dirty all sticky state, then reset in WAIT.
    xact(2, 1'b1, 2'd2, OUTA, 32'h41, n, dout, en, be, wd);
    chk("l4_tx_lat", n, 4);
    xact(2, 1'b1, 2'd0, EXA, 32'h63, n, dout, en, be, wd);
    xact(2, 1'b0, 2'd0, 32'h0, 32'h0, n, dout, en, be, wd);
    chk("l4_pre_err", 32'(err_o[2]), 32'd1);
    chk("l4_pre_exit", 32'(exit_o[2]), 32'd1);
    chk("l4_pre_txv", 32'(tx_valid[2]), 32'd1);
    @(posedge clk); #1;
    mreq[2] = 1'b1; wr[2] = 1'b1; sz[2] = 2'd0; dad[2] = 32'h0800_0010; din[2] = 32'h1234_5678;
    @(posedge clk); #1;
    mreq[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    chk("ab_ack_n", 32'(ack_n[2]), 32'd1);
    chk("ab_dout", ddt_out[2], 32'd0);
    chk("ab_txv", 32'(tx_valid[2]), 32'd0);
    chk("ab_txd", 32'(tx_data[2]), 32'd0);
    chk("ab_exit_o", 32'(exit_o[2]), 32'd0);
    chk("ab_exit_code", exit_code[2], 32'd0);
    chk("ab_err", 32'(err_o[2]), 32'd0);
    got = 0;
    repeat (8) begin @(posedge clk); #1; if (!ack_n[2]) got++; end
    chk("ab_noack", got, 0);
    xact(2, 1'b0, 2'd0, 32'h0800_0010, 32'h0, n, dout, en, be, wd);
    chk("ab_kept_lat", n, 4);
    chk("ab_kept_data", dout, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dbus_ctrl.md
DBUS_CTRL -- requirements
Module: dbus_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- LATENCY, 1, request-accept to ACKD_n cycles; legal 1..15.
- DMEM_BASE, 32'h0800_0000, data SRAM base byte address.
- DMEM_AW, 10, SRAM word-address width (4 KiB).
- STDOUT_ADDR, 32'hf000_0000, console byte port.
- EXIT_ADDR, 32'hff00_0000, program-exit port.
- TXQ_DEPTH, 8, console FIFO entries (power of 2).
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous reset, active-high.
- MREQ, in, 1, core data request.
- WRITE, in, 1, 1 = store, 0 = load.
- SIZE, in, 2, 00 word, 01 half, 10 byte; 11 treated as byte.
- DAD, in, 32, byte address.
- DDT_in, in, 32, store data, right-aligned.
- DDT_out, out, 32, load data, right-aligned, zero-extended.
- ACKD_n, out, 1, active-low one-cycle completion.
- sram_en / sram_we, out, 1 / 1, SRAM enable / write.
- sram_be, out, 4, byte enables; lane k = bits [8k+7:8k].
- sram_addr, out, DMEM_AW, word address.
- sram_wdata, out, 32, lane-steered write data.
- sram_rdata, in, 32, SRAM read data, valid one cycle after sram_en.
- tx_valid / tx_ready, out / in, 1 / 1, console FIFO head handshake.
- tx_data, out, 8, console byte.
- exit_o, out, 1, sticky exit flag.
- exit_code, out, 32, DDT_in captured at the exit store.
- err_o, out, 1, sticky misaligned/unmapped flag.

Function
REQ-003 FSM states IDLE, WAIT, ACK; one request in flight.
REQ-004 IDLE & MREQ accepts the request (cycle A); DAD, WRITE, SIZE and DDT_in are captured at edge A.
REQ-005 SRAM access in cycle A, combinational from the inputs: sram_en=1 when DAD is in [DMEM_BASE, DMEM_BASE+4*2^DMEM_AW) and aligned; sram_addr=DAD[DMEM_AW+1:2].
REQ-006 Byte lane = DAD[1:0]; half lane = DAD[1]; byte enables: word 1111, half 0011/1100, byte one-hot.
REQ-007 Load data: the selected lane(s) of the sram_rdata latched in cycle A+1, shifted to bit 0 and zero-extended.
REQ-008 ACKD_n=0 in exactly cycle A+LATENCY and 1 otherwise; DDT_out is valid in that cycle and holds until the next ACK.
REQ-009 From IDLE, LATENCY=1 goes directly to ACK; otherwise to WAIT, with the counter loaded to LATENCY-1 and decremented to 1.
REQ-010 ACK always returns to IDLE; MREQ is ignored in ACK; back-to-back requests have a 1-cycle minimum gap.
REQ-011 Misaligned access (word with DAD[1:0]!=0, half with DAD[0]=1) or an unmapped non-MMIO address: no SRAM enable, err_o=1, normal ACK, load returns 0.
REQ-012 STDOUT_ADDR store: pushes DDT_in[7:0] into the FIFO at accept; with the FIFO full, IDLE does not accept (no ACK) until a slot frees.
REQ-013 Push and pop in the same cycle on a full FIFO is not accepted; on a non-full FIFO both occur and the count is unchanged.
REQ-014 FIFO pop occurs on tx_valid & tx_ready; tx_valid = !empty; pointers wrap modulo TXQ_DEPTH.
REQ-015 EXIT_ADDR store: exit_o=1, exit_code=DDT_in, normal ACK; later exit stores are ignored.
REQ-016 MMIO loads return 0 with a normal ACK.

Reset
REQ-017 rst=1 at an edge forces: IDLE; counter 0; ACKD_n=1; DDT_out=0; FIFO empty (tx_valid=0, tx_data=0); exit_o=0; exit_code=0; err_o=0.
REQ-018 Combinational SRAM outputs are 0 while rst=1.
REQ-019 rst mid-transaction aborts it: no ACK is issued afterwards, and an accepted store already written to SRAM is not rolled back.

Verification
REQ-020 LATENCY=1, load word at 0x0800_0004 with SRAM word 0xDEADBEEF -> ACKD_n low in cycle A+1, DDT_out=0xDEADBEEF.
REQ-021 LATENCY=3, byte store 0x5A to 0x0800_0003 -> sram_be=1000, sram_wdata[31:24]=0x5A, ACK only in A+3; a later half load from 0x0800_0002 -> DDT_out=0x0000_5Axx.
REQ-022 With tx_ready=0, nine byte stores to STDOUT_ADDR -> eight ACKs, the ninth stalls; one tx_ready pulse -> ninth ACK, FIFO order preserved.
REQ-023 Word load at 0x0800_0002 -> no sram_en, err_o=1, DDT_out=0, ACK issued.
REQ-024 Store 0x0000_002A to EXIT_ADDR -> exit_o=1, exit_code=0x2A; a second exit store of 7 leaves exit_code=0x2A.
REQ-025 rst asserted in WAIT with LATENCY=4 -> no ACK afterwards, all outputs at reset values next cycle.
